// File: rtl/iterative_alu_if.sv
// Handshaked operand/result bus for iterative_alu.
// master = issuing stage (decode/operand fetch + writeback), slave = the ALU.
interface iterative_alu_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            negative;

  modport master (
    output in_valid, op, rs1, rs2, out_ready,
    input  in_ready, out_valid, result, zero, negative
  );

  modport slave (
    input  in_valid, op, rs1, rs2, out_ready,
    output in_ready, out_valid, result, zero, negative
  );
endinterface

// File: rtl/iterative_alu.sv
// Registered, handshaked ALU: single-cycle base ops, optional 1-bit-per-cycle mul/div.
// Define ALU_MULDIV_EN to build the multiply/divide datapath and BUSY state.
module iterative_alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  iterative_alu_if.slave  bus,
  output logic            busy
);
  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic            accept;
  logic            md_start;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  logic [XLEN-1:0] res_d;
  logic            res_we;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            neg_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign shamt  = bus.rs2[SHW-1:0];

  // Base ops; every op[4]=1 code also lands here as 0 unless it starts an iteration.
  always_comb begin
    base_res = '0;
    if (!bus.op[4]) begin
      case (bus.op[3:0])
        4'h0:    base_res = bus.rs1 + bus.rs2;
        4'h1:    base_res = bus.rs1 - bus.rs2;
        4'h2:    base_res = bus.rs1 ^ bus.rs2;
        4'h3:    base_res = bus.rs1 | bus.rs2;
        4'h4:    base_res = bus.rs1 & bus.rs2;
        4'h5:    base_res = bus.rs1 << shamt;
        4'h6:    base_res = bus.rs1 >> shamt;
        4'h7:    base_res = $signed(bus.rs1) >>> shamt;
        4'h8:    base_res = {{(XLEN-1){1'b0}}, $signed(bus.rs1) < $signed(bus.rs2)};
        4'h9:    base_res = {{(XLEN-1){1'b0}}, bus.rs1 < bus.rs2};
        default: base_res = '0;
      endcase
    end
  end

`ifdef ALU_MULDIV_EN
  localparam logic [SHW:0] CntLast = (SHW+1)'(XLEN);
  localparam logic [SHW:0] CntOne  = (SHW+1)'(1);

  logic [SHW:0]    cnt_q;
  logic [XLEN-1:0] acc_q;   // product high half / partial remainder
  logic [XLEN-1:0] lo_q;    // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0] opnd_q;  // multiplicand / divisor magnitude
  logic            md_div_q, md_sel_q, quo_neg_q, rem_neg_q, div0_q;
  logic            sgn1, sgn2;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;
  logic [XLEN-1:0] md_res;

  // 10000, 10001, 10100..10111
  assign md_start = bus.op[4] & ~bus.op[3] & (bus.op[2] | ~bus.op[1]);
  assign sgn1     = bus.op[1] & bus.rs1[XLEN-1];
  assign sgn2     = bus.op[1] & bus.rs2[XLEN-1];

  assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q, lo_q[XLEN-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};

  always_comb begin
    if (!md_div_q) begin
      md_res = md_sel_q ? acc_q : lo_q;
    end else if (md_sel_q) begin
      md_res = rem_neg_q ? -acc_q : acc_q;
    end else begin
      md_res = div0_q ? '1 : (quo_neg_q ? -lo_q : lo_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (accept && md_start) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      md_div_q  <= bus.op[2];
      md_sel_q  <= bus.op[0];
      quo_neg_q <= sgn1 ^ sgn2;
      rem_neg_q <= sgn1;
      div0_q    <= (bus.rs2 == '0);
      if (bus.op[2]) begin
        lo_q   <= sgn1 ? -bus.rs1 : bus.rs1;
        opnd_q <= sgn2 ? -bus.rs2 : bus.rs2;
      end else begin
        lo_q   <= bus.rs2;
        opnd_q <= bus.rs1;
      end
    end else if (state_q == StBusy && cnt_q != CntLast) begin
      cnt_q <= cnt_q + CntOne;
      if (!md_div_q) begin
        acc_q <= mul_sum[XLEN:1];
        lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
      end else if (!div_diff[XLEN+1]) begin
        acc_q <= div_diff[XLEN-1:0];
        lo_q  <= {lo_q[XLEN-2:0], 1'b1};
      end else begin
        acc_q <= div_shift[XLEN-1:0];
        lo_q  <= {lo_q[XLEN-2:0], 1'b0};
      end
    end
  end
`else
  assign md_start = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = md_start ? StBusy : StDone;
`ifdef ALU_MULDIV_EN
      StBusy: if (cnt_q == CntLast) state_d = StDone;
`endif
      StDone: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
`ifdef ALU_MULDIV_EN
    busy = (state_q == StBusy);
`else
    busy = 1'b0;
`endif
  end

  // Flags are captured from the value being written, so they always match result.
  always_comb begin
    res_d  = base_res;
    res_we = accept & ~md_start;
`ifdef ALU_MULDIV_EN
    if (state_q == StBusy && cnt_q == CntLast) begin
      res_d  = md_res;
      res_we = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
    end else if (res_we) begin
      result_q <= res_d;
      zero_q   <= (res_d == '0);
      neg_q    <= res_d[XLEN-1];
    end
  end

  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.negative = neg_q;
endmodule
